// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the if_id_queue.
// The queue uses the slave view; the fetch/decode side uses master.
interface if_id_queue_if #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_misalign;

    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_misalign
    );

    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_misalign
    );
endinterface

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: DEPTH-entry circular buffer of {pc, inst}
// with a misalignment flag per entry; flush drops everything.
module if_id_queue #(
    parameter int DEPTH  = 2,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    if_id_queue_if.slave                 q,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              mis_mem  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Ready and valid come from registered occupancy only, never from out_ready.
    always_comb begin
        q.in_ready  = (count != CNT_W'(DEPTH));
        q.out_valid = (count != '0);
        push        = q.in_valid && q.in_ready && !q.flush;
        pop         = q.out_valid && q.out_ready && !q.flush;
    end

    always_comb begin
        q.out_pc       = '0;
        q.out_inst     = '0;
        q.out_misalign = 1'b0;
        if (q.out_valid) begin
            q.out_pc       = pc_mem[rd_ptr];
            q.out_inst     = inst_mem[rd_ptr];
            q.out_misalign = mis_mem[rd_ptr];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
                mis_mem[i]  <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= q.in_pc;
                inst_mem[wr_ptr] <= q.in_inst;
                mis_mem[wr_ptr]  <= (q.in_pc[1:0] != 2'b00);
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: accepted pushes are queued as expected
// entries and compared in order as decode consumes them.
module tb_if_id_queue;
    localparam int DEPTH = 2;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        mis;
    } entry_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] count;
    int         n_cmp = 0;
    int         n_mis = 0;
    int         n_push = 0;
    int         n_pop = 0;
    entry_t     exp_q[$];

    if_id_queue_if #(.PC_W(64), .INST_W(32)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .PC_W(64), .INST_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .q     (bus),
        .count (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [31:0] inst);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
    endtask

    // Monitor between edges: inputs are stable here and hold through the next edge.
    always @(negedge clock) begin
        if (reset) begin
            check("mon_count", 64'(count), 64'(exp_q.size()));
            check("mon_out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            check("mon_in_ready", 64'(bus.in_ready), 64'(exp_q.size() != DEPTH));
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", 64'(bus.out_valid), 64'd0);
                    end else begin
                        entry_t e;
                        e = exp_q.pop_front();
                        check("sb_pc", bus.out_pc, e.pc);
                        check("sb_inst", 64'(bus.out_inst), 64'(e.inst));
                        check("sb_misalign", 64'(bus.out_misalign), 64'(e.mis));
                        n_pop++;
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    entry_t e;
                    e.pc   = bus.in_pc;
                    e.inst = bus.in_inst;
                    e.mis  = (bus.in_pc[1:0] != 2'b00);
                    exp_q.push_back(e);
                    n_push++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int start;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset and first fetch
        repeat (3) begin
            tick();
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_out_pc", bus.out_pc, 64'd0);
            check("rst_out_inst", 64'(bus.out_inst), 64'd0);
            check("rst_count", 64'(count), 64'd0);
            check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        end
        reset = 1'b1;
        drive(64'h8000_0000, 32'h0000_0413);
        tick();
        check("first_valid", 64'(bus.out_valid), 64'd1);
        check("first_pc", bus.out_pc, 64'h8000_0000);
        check("first_inst", 64'(bus.out_inst), 64'h0000_0413);
        check("first_count", 64'(count), 64'd1);

        // Fill and back-pressure, third entry held until accepted
        drive(64'h8000_0004, 32'h0010_0093);
        tick();
        check("full_count", 64'(count), 64'd2);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        drive(64'h8000_0008, 32'h0020_0113);
        start = n_push;
        tick();
        tick();
        check("full_hold_count", 64'(count), 64'd2);
        check("full_no_accept", 64'(n_push), 64'(start));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && n_push == start; i++) tick();
        check("held_accepted", 64'(n_push), 64'(start + 1));
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && bus.out_valid; i++) tick();
        check("drain_empty", 64'(bus.out_valid), 64'd0);
        check("drain_pops", 64'(n_pop), 64'd3);

        // Streaming: one in, one out per cycle
        start = n_pop;
        for (int k = 0; k < 8; k++) begin
            drive(64'h8000_1000 + 64'(4 * k), 32'h0000_0013 + 32'(k));
            tick();
            check("stream_count", 64'(count), 64'd1);
            check("stream_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_pops", 64'(n_pop - start), 64'd8);
        check("stream_empty", 64'(bus.out_valid), 64'd0);

        // Flush priority over push and pop
        bus.out_ready = 1'b0;
        drive(64'h8000_0200, 32'h0000_0513);
        tick();
        drive(64'h8000_0204, 32'h0000_0593);
        tick();
        check("pre_flush_count", 64'(count), 64'd2);
        drive(64'h8000_0100, 32'h0000_0613);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        drive(64'h8000_0104, 32'h0000_0693);
        repeat (2) begin
            tick();
            check("flush_b2b_count", 64'(count), 64'd0);
        end
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("post_flush_valid", 64'(bus.out_valid), 64'd0);

        // Misalignment flag
        bus.out_ready = 1'b0;
        drive(64'h8000_0002, 32'h0000_0013);
        tick();
        drive(64'h8000_0004, 32'h0000_0093);
        tick();
        bus.in_valid = 1'b0;
        check("mis_pc", bus.out_pc, 64'h8000_0002);
        check("mis_flag", 64'(bus.out_misalign), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("aligned_pc", bus.out_pc, 64'h8000_0004);
        check("aligned_flag", 64'(bus.out_misalign), 64'd0);
        check("aligned_count", 64'(count), 64'd1);

        // Asynchronous reset between edges
        drive(64'h8000_0008, 32'h0000_0113);
        tick();
        bus.in_valid = 1'b0;
        check("pre_arst_count", 64'(count), 64'd2);
        @(posedge clock);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_pc", bus.out_pc, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        drive(64'h8000_0000, 32'h0000_0413);
        tick();
        bus.in_valid = 1'b0;
        check("refetch_valid", 64'(bus.out_valid), 64'd1);
        check("refetch_pc", bus.out_pc, 64'h8000_0000);
        check("refetch_inst", 64'(bus.out_inst), 64'h0000_0413);
        check("refetch_count", 64'(count), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        check("final_empty", 64'(bus.out_valid), 64'd0);
        check("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling queue between the instruction fetch unit and the decode unit of the single-issue RV64 core.
- Captures each fetched {pc, inst} pair behind a valid/ready handshake.
- Holds up to DEPTH entries so decode back-pressure does not lose instructions.
- Discards all queued instructions on a branch/jump redirect flush.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- PC_W, 64, program counter width.
- INST_W, 32, instruction width.

Ports:
- clock  in  1  core clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset: asserts immediately when low, deasserts synchronously to clock.
- in_valid  in  1  fetch stage presents a valid instruction.
- in_ready  out  1  queue can accept an entry this cycle.
- in_pc  in  PC_W  pc of the presented instruction.
- in_inst  in  INST_W  fetched instruction word.
- flush  in  1  redirect; drop all entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc  out  PC_W  pc of the head entry.
- out_inst  out  INST_W  instruction of the head entry.
- out_misalign  out  1  head pc has pc[1:0] != 0.
- count  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset low):
  - count = 0; read and write pointers = 0; all storage cleared to 0.
  - out_valid = 0, out_pc = 0, out_inst = 0, out_misalign = 0, in_ready = 1.
- Push: in_valid && in_ready && !flush at the rising edge.
  - Writes {in_pc, in_inst, in_pc[1:0] != 0} at the write pointer.
  - Write pointer increments modulo DEPTH.
- Pop: out_valid && out_ready && !flush at the rising edge; read pointer increments modulo DEPTH.
- in_ready = (count != DEPTH). It depends only on registered state; there is no combinational path from out_ready.
- out_valid = (count != 0). out_pc, out_inst and out_misalign come from the head register.
- Output fields are forced to 0 whenever out_valid = 0.
- Latency:
  - An entry pushed at edge N into an empty queue appears on the outputs after edge N.
  - No same-cycle bypass from in_* to out_*.
- Throughput: one push and one pop per cycle sustained.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Not possible when full, since in_ready = 0.
  - When empty, the pop is ignored (out_valid = 0) and the push proceeds.
- Full: in_valid is held off; the upstream stage must keep in_pc/in_inst stable until accepted.
- Flush has priority over push and pop in the same cycle:
  - count -> 0 and both pointers -> 0.
  - The presented push is dropped and the head is not counted as consumed.
  - After the edge: out_valid = 0, in_ready = 1.
- Back-to-back flush cycles keep the queue empty.
- in_valid, out_ready and flush sampled while reset is low are ignored.
- Reset asserted mid-operation clears state immediately; no pending entry survives.
- count arithmetic is unsigned.
  - count never exceeds DEPTH and never underflows.
  - Pointer wrap from DEPTH-1 to 0 has no gap.

Test Plan:
- Reset and first fetch:
  - Stimulus: hold reset low 3 cycles, release, then push pc=0x80000000 inst=0x00000413 with out_ready=0.
  - Response: during reset out_valid=0 and outputs are 0. One cycle after the push, out_valid=1, out_pc=0x80000000, out_inst=0x00000413, count=1.
- Fill and back-pressure:
  - Stimulus: out_ready=0, push pcs 0x80000000 and 0x80000004.
  - Response: count=2, in_ready=0; a third in_valid is not accepted. Raising out_ready drains the entries in order 0x80000000 then 0x80000004, then out_valid=0.
- Streaming:
  - Stimulus: in_valid=1 and out_ready=1 continuously for 8 sequential pcs stepping by 4.
  - Response: after one cycle of latency, one instruction is delivered per cycle in order with no bubbles; count stays at 1; pointers wrap correctly.
- Flush priority:
  - Stimulus: queue holds 2 entries; assert flush together with in_valid=1 (pc 0x80000100) and out_ready=1.
  - Response: next cycle count=0, out_valid=0, in_ready=1; pc 0x80000100 is never output.
- Misalignment flag:
  - Stimulus: push pc=0x80000002.
  - Response: out_misalign=1 with that entry; the following entry with pc=0x80000004 has out_misalign=0.
- Async reset mid-stream:
  - Stimulus: pull reset low between clock edges while count=2.
  - Response: out_valid=0 and count=0 before the next rising edge; after release the first push behaves as in the reset-and-first-fetch scenario.
